// File: rtl/salamander_stack_pkg.sv
// Shared types and sizing helpers for the call/return stack controller.
package salamander_stack_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PUSH     = 3'd1,
        ST_POP      = 3'd2,
        ST_POP_LAST = 3'd3,
        ST_FIN      = 3'd4
    } stack_ctrl_state_t;

    localparam int STACK_SIZE_DFLT = 4;
    localparam int STACK_CAPACITY  = (2 ** STACK_SIZE_DFLT) - 1;

    // Number of stack words that make up one return-address frame.
    function automatic int nibbles(input int pc_width, input int data_size);
        return pc_width / data_size;
    endfunction

    // One address is reserved by the STACK, so usable capacity is 2**size-1 words.
    function automatic int stack_capacity(input int stack_size);
        return (2 ** stack_size) - 1;
    endfunction

endpackage

// File: rtl/stack_call_ctrl.sv
// Call/return sequencer: splits a return address into stack words on CALL,
// reassembles it on RET, and guards the STACK against overflow/underflow.
module stack_call_ctrl
    import salamander_stack_pkg::*;
#(
    parameter int DATA_SIZE  = 4,
    parameter int STACK_SIZE = 4,
    parameter int PC_WIDTH   = 8
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  CALL_REQ,
    input  logic                  RET_REQ,
    input  logic [PC_WIDTH-1:0]   PC_IN,
    input  logic                  ERR_CLR,
    output logic [PC_WIDTH-1:0]   RET_PC,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  OVF_ERR,
    output logic                  UNF_ERR,
    output logic                  SYNC_ERR,
    output logic [STACK_SIZE-1:0] FRAMES,
    output logic                  STK_W,
    output logic                  STK_R,
    output logic [DATA_SIZE-1:0]  STK_DATA_WR,
    input  logic [DATA_SIZE-1:0]  STK_DATA_RD,
    input  logic                  STK_FULL,
    input  logic                  STK_EMPTY
);

    localparam int NIB   = nibbles(PC_WIDTH, DATA_SIZE);
    localparam int CAP   = stack_capacity(STACK_SIZE);
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam int OCC_W = STACK_SIZE + 1;

    localparam logic [OCC_W-1:0] NIB_OCC  = OCC_W'(NIB);
    localparam logic [OCC_W-1:0] CAP_OCC  = OCC_W'(CAP);
    localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
    localparam logic [OCC_W-1:0] OCC_ZERO = OCC_W'(0);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    stack_ctrl_state_t     state_q;
    logic [OCC_W-1:0]      occ_q;
    logic [STACK_SIZE-1:0] frames_q;
    logic [IDX_W-1:0]      idx_q;
    logic [PC_WIDTH-1:0]   pc_q;
    logic [PC_WIDTH-1:0]   asm_q;
    logic [PC_WIDTH-1:0]   ret_pc_q;
    logic [DATA_SIZE-1:0]  stk_data_wr_q;
    logic                  stk_w_q;
    logic                  stk_r_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  ovf_q;
    logic                  unf_q;
    logic                  sync_q;

    logic call_go_s;
    logic ret_go_s;
    logic call_fit_s;
    logic ret_fit_s;
    logic sync_set_s;
    logic ovf_d;
    logic unf_d;
    logic sync_d;

    // Request arbitration, capacity checks and sticky-flag next state (a new error beats ERR_CLR).
    always_comb begin
        call_go_s  = (state_q == ST_IDLE) && CALL_REQ;
        ret_go_s   = (state_q == ST_IDLE) && !CALL_REQ && RET_REQ;
        call_fit_s = (occ_q + NIB_OCC) <= CAP_OCC;
        ret_fit_s  = occ_q >= NIB_OCC;
        if (state_q == ST_IDLE) begin
            sync_set_s = (STK_EMPTY != (occ_q == OCC_ZERO)) || (STK_FULL != (occ_q == CAP_OCC));
        end else begin
            sync_set_s = 1'b0;
        end
        ovf_d  = (call_go_s && !call_fit_s) || (ovf_q && !ERR_CLR);
        unf_d  = (ret_go_s && !ret_fit_s) || (unf_q && !ERR_CLR);
        sync_d = sync_set_s || (sync_q && !ERR_CLR);
    end

    // Sequencer FSM: owns stack strobes, occupancy, frame count and the returned address.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q       <= ST_IDLE;
            occ_q         <= OCC_ZERO;
            frames_q      <= STACK_SIZE'(0);
            idx_q         <= IDX_ZERO;
            pc_q          <= PC_WIDTH'(0);
            asm_q         <= PC_WIDTH'(0);
            ret_pc_q      <= PC_WIDTH'(0);
            stk_data_wr_q <= DATA_SIZE'(0);
            stk_w_q       <= 1'b0;
            stk_r_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            ovf_q         <= 1'b0;
            unf_q         <= 1'b0;
            sync_q        <= 1'b0;
        end else begin
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
            sync_q <= sync_d;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (call_go_s && call_fit_s) begin
                        state_q       <= ST_PUSH;
                        busy_q        <= 1'b1;
                        stk_w_q       <= 1'b1;
                        pc_q          <= PC_IN;
                        stk_data_wr_q <= PC_IN[DATA_SIZE-1:0];
                        idx_q         <= IDX_ZERO;
                    end else if (ret_go_s && ret_fit_s) begin
                        state_q <= ST_POP;
                        busy_q  <= 1'b1;
                        stk_r_q <= 1'b1;
                        asm_q   <= PC_WIDTH'(0);
                        idx_q   <= IDX_ZERO;
                    end else if (call_go_s || ret_go_s) begin
                        // Rejected request: no stack access, just report completion.
                        state_q <= ST_FIN;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_PUSH: begin
                    occ_q <= occ_q + OCC_ONE;
                    if (idx_q == IDX_LAST) begin
                        state_q       <= ST_FIN;
                        stk_w_q       <= 1'b0;
                        stk_data_wr_q <= DATA_SIZE'(0);
                        busy_q        <= 1'b0;
                        done_q        <= 1'b1;
                        frames_q      <= frames_q + STACK_SIZE'(1);
                    end else begin
                        idx_q         <= idx_q + IDX_ONE;
                        stk_data_wr_q <= DATA_SIZE'(pc_q >> (DATA_SIZE * (int'(idx_q) + 1)));
                    end
                end
                ST_POP: begin
                    occ_q <= occ_q - OCC_ONE;
                    // Read data trails the R strobe by one cycle; most significant word arrives first.
                    if (idx_q != IDX_ZERO) begin
                        asm_q[(NIB - int'(idx_q)) * DATA_SIZE +: DATA_SIZE] <= STK_DATA_RD;
                    end
                    if (idx_q == IDX_LAST) begin
                        state_q <= ST_POP_LAST;
                        stk_r_q <= 1'b0;
                    end else begin
                        idx_q <= idx_q + IDX_ONE;
                    end
                end
                ST_POP_LAST: begin
                    state_q  <= ST_FIN;
                    ret_pc_q <= asm_q | PC_WIDTH'(STK_DATA_RD);
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    frames_q <= frames_q - STACK_SIZE'(1);
                end
                ST_FIN: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q       <= ST_IDLE;
                    stk_w_q       <= 1'b0;
                    stk_r_q       <= 1'b0;
                    stk_data_wr_q <= DATA_SIZE'(0);
                    busy_q        <= 1'b0;
                end
            endcase
        end
    end

    assign RET_PC      = ret_pc_q;
    assign BUSY        = busy_q;
    assign DONE        = done_q;
    assign OVF_ERR     = ovf_q;
    assign UNF_ERR     = unf_q;
    assign SYNC_ERR    = sync_q;
    assign FRAMES      = frames_q;
    assign STK_W       = stk_w_q;
    assign STK_R       = stk_r_q;
    assign STK_DATA_WR = stk_data_wr_q;

endmodule
